// File: rtl/program_mem_responder_if.sv
// Fetch-side and program-memory-side signals of the responder.
// The slave modport is the responder's view; master is the fetchers-plus-memory view.
interface program_mem_responder_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 2
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic                                    mem_read_valid;
  logic [ADDR_BITS-1:0]                    mem_read_address;
  logic                                    mem_read_ready;
  logic [DATA_BITS-1:0]                    mem_read_data;

  modport slave (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport master (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_mem_responder.sv
// Round-robin instruction-fetch responder: many fetchers share one program-memory read port.
// Each consumer's response register and ready pulse live in a per-consumer lane.
module program_mem_responder_lane #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data
);
  // data holds its last word until this lane is loaded again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      data  <= '0;
    end else begin
      ready <= load;
      if (load) data <= load_data;
    end
  end
endmodule

module program_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 2
) (
  input logic                   clk,
  input logic                   reset,
  program_mem_responder_if.slave bus
);
  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAITING = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]             state;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       winner;
  logic                   found;
  logic                   deliver;
  logic                   mem_valid_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [NUM_CONSUMERS-1:0]                lane_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lane_data;

  // scan starts one past the last winner so every requester is served once per N grants
  always_comb begin : arb
    int               j;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    j      = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CONSUMERS) j = j - NUM_CONSUMERS;
      cand = IDX_W'(j);
      if (!found && bus.consumer_read_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign deliver = (state == WAITING) && bus.mem_read_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= IDX_W'(NUM_CONSUMERS - 1);
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant       <= winner;
          rr_ptr      <= winner;
          mem_addr_q  <= bus.consumer_read_address[winner];
          mem_valid_q <= 1'b1;
          state       <= WAITING;
        end
        WAITING: if (bus.mem_read_ready) begin
          mem_valid_q <= 1'b0;
          state       <= RESPOND;
        end
        RESPOND: state <= RELEASE;
        // fetchers drop valid a cycle after ready; hold off until they do
        RELEASE: if (!bus.consumer_read_valid[grant]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
    program_mem_responder_lane #(.DATA_BITS(DATA_BITS)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (deliver && (grant == IDX_W'(g))),
      .load_data (bus.mem_read_data),
      .ready     (lane_ready[g]),
      .data      (lane_data[g])
    );
  end

  assign bus.consumer_read_ready = lane_ready;
  assign bus.consumer_read_data  = lane_data;
  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_address    = mem_addr_q;
endmodule

// File: tb/tb_program_mem_responder.sv
// Directed bench for program_mem_responder: scripted fetchers and memory, a transaction-level
// reference checked every cycle, and literal expectations for the named scenarios.
module tb_program_mem_responder;
  localparam int N = 2;
  localparam int A = 8;
  localparam int D = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_mem_responder_if #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) bus ();

  program_mem_responder #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- program memory ----------------
  logic [D-1:0] mem_table [256];
  int mem_wait = 3;
  bit stray    = 1'b0;
  int mcnt     = 0;
  bit auto_rdy;

  initial begin
    for (int i = 0; i < 256; i++) mem_table[i] = {8'(i), ~8'(i)};
    mem_table[8'h05] = 16'hA1B2;
    mem_table[8'h10] = 16'h1010;
    mem_table[8'h20] = 16'h2020;
    mem_table[8'h30] = 16'h1234;
    mem_table[8'h40] = 16'h5678;
  end

  always @(negedge clk) begin
    auto_rdy = 1'b0;
    if (reset || !bus.mem_read_valid) mcnt = 0;
    else if (mcnt == mem_wait) begin
      auto_rdy = 1'b1;
      mcnt     = 0;
    end else mcnt++;
    bus.mem_read_ready = auto_rdy | stray;
    bus.mem_read_data  = auto_rdy ? mem_table[bus.mem_read_address] : (stray ? 16'hDEAD : 16'h0000);
  end

  // ---------------- fetchers ----------------
  int         remaining [N];
  int         hold      [N];
  int         cnt       [N];
  int         gap       [N];
  logic [A-1:0] faddr   [N];

  initial begin
    bus.consumer_read_valid   = '0;
    bus.consumer_read_address = '0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0; hold[i] = 0; cnt[i] = 0; gap[i] = 0; faddr[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.consumer_read_valid[1'(i)]) begin
        if (bus.consumer_read_ready[1'(i)]) begin
          remaining[i]--;
          cnt[i] = hold[i];
          if (cnt[i] == 0) begin
            bus.consumer_read_valid[1'(i)] = 1'b0;
            gap[i] = 2;
          end
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            bus.consumer_read_valid[1'(i)] = 1'b0;
            gap[i] = 2;
          end
        end
      end else if (gap[i] > 0) gap[i]--;
      else if (remaining[i] > 0) begin
        bus.consumer_read_valid[1'(i)]   = 1'b1;
        bus.consumer_read_address[1'(i)] = faddr[i];
      end
    end
  end

  // log of issued memory addresses, one entry per new request
  logic [A-1:0] addr_log [$];
  logic prev_mv = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_read_valid && !prev_mv) addr_log.push_back(bus.mem_read_address);
    prev_mv = bus.mem_read_valid;
  end

  // ---------------- reference model ----------------
  // Transaction view: an owner holds the port from grant until it has been answered and
  // has been seen dropping valid at least one cycle after the answer.
  int           m_owner = -1;
  int           m_last  = N - 1;
  bit           m_pending = 1'b0;
  int           m_age   = 0;
  logic         e_mv    = 1'b0;
  logic [A-1:0] e_ma    = '0;
  logic [N-1:0] e_rdy   = '0;
  logic [D-1:0] e_data [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_pending = 1'b0; m_age = 0;
      e_mv = 1'b0; e_ma = '0; e_rdy = '0;
      for (int i = 0; i < N; i++) e_data[i] = '0;
    end else begin
      e_rdy = '0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (m_owner < 0 && bus.consumer_read_valid[1'(j)]) begin
            m_owner   = j;
            m_last    = j;
            m_pending = 1'b1;
            e_mv      = 1'b1;
            e_ma      = bus.consumer_read_address[1'(j)];
          end
        end
      end else if (m_pending) begin
        if (bus.mem_read_ready) begin
          e_data[m_owner]    = bus.mem_read_data;
          e_rdy[1'(m_owner)] = 1'b1;
          m_pending = 1'b0;
          e_mv      = 1'b0;
          m_age     = 0;
        end
      end else if (m_age >= 1 && !bus.consumer_read_valid[1'(m_owner)]) m_owner = -1;
      else m_age++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("mem_read_valid", 32'(bus.mem_read_valid), 32'(e_mv));
    chk("mem_read_address", 32'(bus.mem_read_address), 32'(e_ma));
    chk("consumer_read_ready", 32'(bus.consumer_read_ready), 32'(e_rdy));
    for (int i = 0; i < N; i++)
      chk($sformatf("consumer_read_data%0d", i), 32'(bus.consumer_read_data[1'(i)]), 32'(e_data[i]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int c, input int lim, input string name);
    int t = 0;
    while (!bus.consumer_read_ready[1'(c)] && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_in_time"}, 32'(t < lim), 32'd1);
  endtask

  task automatic wait_idle(input int lim, input string name);
    int t = 0;
    while ((remaining[0] != 0 || remaining[1] != 0 || bus.consumer_read_valid != '0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_in_time"}, 32'(t < lim), 32'd1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_read_address), 32'd0);
    chk("reset_ready", 32'(bus.consumer_read_ready), 32'd0);
    chk("reset_data", 32'(bus.consumer_read_data), 32'd0);
    #1;
    reset = 1'b0;

    // round robin: both fetchers keep requesting
    sync();
    addr_log.delete();
    mem_wait = 1;
    faddr[0] = 8'h10; faddr[1] = 8'h20;
    remaining[0] = 2; remaining[1] = 2;
    wait_idle(200, "rr");
    chk("rr_count", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() >= 3) begin
      chk("rr_addr0", 32'(addr_log[0]), 32'h10);
      chk("rr_addr1", 32'(addr_log[1]), 32'h20);
      chk("rr_addr2", 32'(addr_log[2]), 32'h10);
    end
    chk("rr_data0", 32'(bus.consumer_read_data[0]), 32'h1010);
    chk("rr_data1", 32'(bus.consumer_read_data[1]), 32'h2020);

    // single request with 3 wait cycles, valid held after ready
    addr_log.delete();
    mem_wait = 3;
    faddr[0] = 8'h05; hold[0] = 3; remaining[0] = 1;
    wait_ready(0, 40, "single");
    chk("single_data", 32'(bus.consumer_read_data[0]), 32'hA1B2);
    chk("single_addr", 32'(bus.mem_read_address), 32'h05);
    @(negedge clk);
    chk("single_pulse_width", 32'(bus.consumer_read_ready[0]), 32'd0);
    repeat (8) @(negedge clk);
    chk("single_no_refetch", 32'(addr_log.size()), 32'd1);
    sync();
    hold[0] = 0;
    wait_idle(40, "single");

    // release guard: fetcher 1 holds valid 2 cycles after ready, fetcher 0 waits
    addr_log.delete();
    mem_wait = 1;
    faddr[0] = 8'h11; faddr[1] = 8'h21; hold[1] = 2;
    remaining[0] = 1; remaining[1] = 1;
    wait_ready(1, 40, "guard");
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 1) begin #1; stray = 1'b1; end
      if (t == 2) begin #1; stray = 1'b0; end
    end while (!bus.mem_read_valid && t < 20);
    chk("guard_regrant_gap", 32'(t), 32'd4);
    wait_ready(0, 40, "guard0");
    chk("guard_data0", 32'(bus.consumer_read_data[0]), 32'h11EE);
    chk("guard_data1_kept", 32'(bus.consumer_read_data[1]), 32'h21DE);
    wait_idle(60, "guard");
    hold[1] = 0;
    chk("guard_order_count", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("guard_order0", 32'(addr_log[0]), 32'h21);
      chk("guard_order1", 32'(addr_log[1]), 32'h11);
    end

    // stray memory ready while idle
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle_ready", 32'(bus.consumer_read_ready), 32'd0);
    end
    sync();
    stray = 1'b0;
    chk("stray_idle_data0", 32'(bus.consumer_read_data[0]), 32'h11EE);
    chk("stray_idle_data1", 32'(bus.consumer_read_data[1]), 32'h21DE);

    // data hold across consumers
    faddr[0] = 8'h30; remaining[0] = 1;
    wait_idle(60, "hold0");
    faddr[1] = 8'h40; remaining[1] = 1;
    wait_idle(60, "hold1");
    chk("hold_data0", 32'(bus.consumer_read_data[0]), 32'h1234);
    chk("hold_data1", 32'(bus.consumer_read_data[1]), 32'h5678);

    // reset in the middle of a memory wait
    mem_wait = 5;
    faddr[1] = 8'h50; remaining[1] = 1;
    t = 0;
    while (!bus.mem_read_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_req_issued", 32'(t < 20), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_mem_valid", 32'(bus.mem_read_valid), 32'd0);
    chk("rst_async_mem_addr", 32'(bus.mem_read_address), 32'd0);
    chk("rst_async_data", 32'(bus.consumer_read_data), 32'd0);
    chk("rst_async_ready", 32'(bus.consumer_read_ready), 32'd0);
    sync();
    addr_log.delete();
    mem_wait = 1;
    reset = 1'b0;
    wait_ready(1, 40, "rst_c1");
    chk("rst_c1_data", 32'(bus.consumer_read_data[1]), 32'h50AF);
    wait_idle(60, "rst_c1");
    faddr[0] = 8'h60; faddr[1] = 8'h70;
    remaining[0] = 1; remaining[1] = 1;
    wait_idle(100, "rst_both");
    chk("rst_log_count", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      chk("rst_first", 32'(addr_log[0]), 32'h50);
      chk("rst_then_c0", 32'(addr_log[1]), 32'h60);
      chk("rst_then_c1", 32'(addr_log[2]), 32'h70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_mem_responder.md
# program_mem_responder

Serves instruction-fetch read requests from NUM_CONSUMERS per-core fetchers against a single external program-memory read port. Each cycle it is idle, a round-robin arbiter grants one pending fetcher. The responder forwards that fetcher's address to program memory and waits for the memory handshake. It then returns the instruction word to the granted fetcher with a one-cycle ready pulse. The block sits between the cores' fetchers and the off-chip program memory, one instance per GPU.

## Interface
Parameters:
- ADDR_BITS, 8, program memory address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 2, number of fetchers served (≥1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- consumer_read_valid  input  NUM_CONSUMERS  per-fetcher request; held high until ready seen
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened; consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  output  NUM_CONSUMERS  one-cycle response pulse per fetcher
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flattened; consumer i at [i*DATA_BITS +: DATA_BITS]
- mem_read_valid  output  1  request to program memory
- mem_read_address  output  ADDR_BITS  address to program memory
- mem_read_ready  input  1  memory response valid
- mem_read_data  input  DATA_BITS  memory response word

## Operation
- All outputs registered. Reset values:
  - consumer_read_ready = 0, consumer_read_data = 0
  - mem_read_valid = 0, mem_read_address = 0
  - state IDLE, grant index = 0
  - round-robin pointer = NUM_CONSUMERS-1, so consumer 0 wins first
- States: IDLE, WAITING, RESPOND, RELEASE.
- IDLE:
  - Scan consumer_read_valid starting at pointer+1 (mod NUM_CONSUMERS); first set bit wins.
  - On a win: grant index and pointer ← winner; mem_read_address ← winner's address; mem_read_valid ← 1; go WAITING.
  - No request: stay IDLE.
- WAITING:
  - If mem_read_ready = 1: consumer_read_data[grant] ← mem_read_data; mem_read_valid ← 0; consumer_read_ready[grant] ← 1; go RESPOND.
  - mem_read_valid and mem_read_address stay stable until then.
- RESPOND: consumer_read_ready ← 0; go RELEASE.
- RELEASE:
  - Wait until consumer_read_valid[grant] = 0, then go IDLE.
  - This prevents re-granting a fetcher whose valid falls one cycle after ready.
- consumer_read_data[i] holds its last delivered word until overwritten by the next response to i.
- At most one consumer_read_ready bit is ever high, and only in the cycle after a WAITING→RESPOND transition.
- mem_read_ready is ignored outside WAITING.
- If the granted fetcher drops valid during WAITING, the transaction still completes and the response is still pulsed to it.
- Requests from non-granted consumers are neither lost nor reordered; they wait in IDLE arbitration.

## Timing
- Memory request issue:
  - Consumer valid is sampled high at edge k in IDLE.
  - mem_read_valid is high and the address is valid from edge k.
- Response capture:
  - mem_read_ready is sampled high at edge m in WAITING.
  - consumer_read_ready and data are valid from edge m for exactly one cycle.
  - mem_read_valid is low from edge m.
- Minimum service time per request: IDLE → WAITING → RESPOND → RELEASE → IDLE, which is 4 edges plus memory wait cycles. Back-to-back grants are therefore separated by at least 4 cycles.
- Fairness: with N consumers continuously requesting, each is granted once per N grants.
- Reset asserted mid-transaction:
  - Outputs go to reset values asynchronously; any in-flight memory request is abandoned.
  - After deassertion, arbitration restarts at consumer 0.

## Test plan
- Single request: consumer 0 requests address 0x05; memory returns 0xA1B2 after 3 wait cycles. Expected:
  - mem_read_address = 0x05 while valid.
  - consumer_read_ready[0] pulses exactly 1 cycle with data 0xA1B2.
  - No second memory request while valid[0] remains high.
- Round robin: with NUM_CONSUMERS=2, both fetchers continuously request 0x10 and 0x20. Expected:
  - Memory addresses alternate 0x10, 0x20, 0x10.
  - Each ready goes only to its own consumer, with the matching data.
- Release guard: fetcher 1 holds valid 2 cycles after its ready pulse. Expected: no grant to fetcher 1 until valid drops; fetcher 0's pending request is granted after RELEASE exits.
- Stray memory ready: toggle mem_read_ready while IDLE and RELEASE. Expected: no consumer_read_ready pulse and no data change.
- Reset mid-WAITING: assert reset between clock edges. Expected:
  - mem_read_valid is immediately 0 and all outputs are cleared.
  - After release, a request on consumer 1 alone is granted, and later concurrent requests grant consumer 0 first.
- Data hold: after consumer 0 receives 0x1234, serve consumer 1 with 0x5678. Expected: consumer_read_data for consumer 0 still reads 0x1234.
